// File: rtl/uart_rx_core_if.sv
// Register-side bundle of the UART receiver: received data, status flags and the flag clear.
// The receive core drives it through the master modport; the control/status register reads it through slave.
interface uart_rx_core_if;
  logic [7:0] rxbuf;
  logic       rx_9bit;
  logic       rxpnd;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;
  logic       rxpnd_clr;

  modport master (
    output rxbuf, rx_9bit, rxpnd, frame_err, overrun, rx_busy,
    input  rxpnd_clr
  );

  modport slave (
    input  rxbuf, rx_9bit, rxpnd, frame_err, overrun, rx_busy,
    output rxpnd_clr
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART serial receive engine: synchronizes the rx pin, recovers each bit by mid-bit majority vote
// and hands framed bytes (plus optional 9th bit) to the register side with pending/error flags.
module uart_rx_core #(
  parameter int SYNC_STAGES = 2
) (
  input  logic           uart_clk,
  input  logic           sys_rstn,
  input  logic           uart_en,
  input  logic           baud_edge,
  input  logic [15:0]    uart_baud,
  input  logic           prty_en,
  input  logic           uart_rx,
  uart_rx_core_if.master rx_bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, rx_d, start_det;
  logic [15:0]            cnt_q, half;
  logic                   multi, end_of_bit, samp_a, samp_b, sample_pt, bit_val;
  logic                   s_a_q, s_b_q;
  logic [2:0]             bitidx_q;
  logic [7:0]             shreg_q, rxbuf_q;
  logic                   par_q, rx_9bit_q, rxpnd_q, frame_err_q, overrun_q, rx_busy_q;
  logic                   complete, shift_en, par_latch;

  // Idle line is 1, so the synchronizer resets high to avoid a phantom start edge.
  always_ff @(posedge uart_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      sync_q <= '1;
      rx_d   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx};
      rx_d   <= rx_s;
    end
  end

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign start_det = rx_d & ~rx_s;

  assign half       = {1'b0, uart_baud[15:1]};
  assign multi      = |uart_baud[15:1];
  assign end_of_bit = baud_edge & (cnt_q == uart_baud);
  assign samp_a     = baud_edge & multi & (cnt_q == half - 16'd1);
  assign samp_b     = baud_edge & multi & (cnt_q == half);
  assign sample_pt  = baud_edge & (multi ? (cnt_q == half + 16'd1) : (cnt_q == half));
  assign bit_val    = multi ? ((s_a_q & s_b_q) | (s_a_q & rx_s) | (s_b_q & rx_s)) : rx_s;

  always_ff @(posedge uart_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      s_a_q <= 1'b0;
      s_b_q <= 1'b0;
    end else begin
      if (samp_a) s_a_q <= rx_s;
      if (samp_b) s_b_q <= rx_s;
    end
  end

  // The bit timer only runs inside a frame, so every frame begins counting from zero.
  always_ff @(posedge uart_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      cnt_q <= '0;
    end else if (!uart_en || state_q == IDLE || end_of_bit) begin
      cnt_q <= '0;
    end else if (baud_edge) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  always_ff @(posedge uart_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      bitidx_q <= '0;
    end else if (!uart_en || state_q != DATA) begin
      bitidx_q <= '0;
    end else if (end_of_bit) begin
      bitidx_q <= bitidx_q + 3'd1;
    end
  end

  always_ff @(posedge uart_clk or negedge sys_rstn) begin
    if (!sys_rstn) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // STOP completes at its sample point rather than at end-of-bit so a back-to-back start is caught.
  always_comb begin
    state_d   = state_q;
    complete  = 1'b0;
    shift_en  = 1'b0;
    par_latch = 1'b0;
    case (state_q)
      IDLE:  if (start_det) state_d = START;
      START: begin
        if (sample_pt && bit_val) state_d = IDLE;
        else if (end_of_bit)      state_d = DATA;
      end
      DATA: begin
        shift_en = sample_pt;
        if (end_of_bit && bitidx_q == 3'd7) state_d = prty_en ? PAR : STOP;
      end
      PAR: begin
        par_latch = sample_pt;
        if (end_of_bit) state_d = STOP;
      end
      STOP: begin
        if (sample_pt) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!uart_en) begin
      state_d   = IDLE;
      complete  = 1'b0;
      shift_en  = 1'b0;
      par_latch = 1'b0;
    end
  end

  always_ff @(posedge uart_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      shreg_q <= '0;
      par_q   <= 1'b0;
    end else begin
      if (shift_en)  shreg_q <= {bit_val, shreg_q[7:1]};
      if (par_latch) par_q   <= bit_val;
    end
  end

  // A completing frame takes priority over a same-cycle clear; overrun only sets against a stale byte.
  always_ff @(posedge uart_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      rxbuf_q     <= '0;
      rx_9bit_q   <= 1'b0;
      rxpnd_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      rx_busy_q <= (state_d != IDLE);
      if (complete) begin
        rxbuf_q     <= shreg_q;
        rx_9bit_q   <= prty_en & par_q;
        rxpnd_q     <= 1'b1;
        frame_err_q <= ~bit_val;
        if (rxpnd_q && !rx_bus.rxpnd_clr) overrun_q <= 1'b1;
        else if (rx_bus.rxpnd_clr)        overrun_q <= 1'b0;
      end else if (rx_bus.rxpnd_clr) begin
        rxpnd_q     <= 1'b0;
        frame_err_q <= 1'b0;
        overrun_q   <= 1'b0;
      end
    end
  end

  assign rx_bus.rxbuf     = rxbuf_q;
  assign rx_bus.rx_9bit   = rx_9bit_q;
  assign rx_bus.rxpnd     = rxpnd_q;
  assign rx_bus.frame_err = frame_err_q;
  assign rx_bus.overrun   = overrun_q;
  assign rx_bus.rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: drives serial frames bit by bit and compares the register-side outputs
// against a frame-level model of the receive rules (received byte, 9th bit, pending/error flags).
module tb_uart_rx_core;
  logic        uart_clk  = 1'b0;
  logic        baud_edge = 1'b1;
  logic        sys_rstn, uart_en, prty_en, uart_rx;
  logic [15:0] uart_baud;
  int          edge_mode = 0;
  int          tests_run = 0;
  int          tests_failed = 0;

  logic [7:0]  exp_buf;
  logic        exp_9, exp_pnd, exp_ferr, exp_ovr;

  uart_rx_core_if rx_bus();

  uart_rx_core #(.SYNC_STAGES(2)) dut (
    .uart_clk (uart_clk),
    .sys_rstn (sys_rstn),
    .uart_en  (uart_en),
    .baud_edge(baud_edge),
    .uart_baud(uart_baud),
    .prty_en  (prty_en),
    .uart_rx  (uart_rx),
    .rx_bus   (rx_bus)
  );

  always #5 uart_clk = ~uart_clk;

  // Sub-tick is either every cycle or a random ~50% pattern.
  always @(negedge uart_clk)
    baud_edge = (edge_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_rxbuf"},   16'(rx_bus.rxbuf),     16'(exp_buf));
    checkOutput({tag, "_rx9"},     16'(rx_bus.rx_9bit),   16'(exp_9));
    checkOutput({tag, "_rxpnd"},   16'(rx_bus.rxpnd),     16'(exp_pnd));
    checkOutput({tag, "_ferr"},    16'(rx_bus.frame_err), 16'(exp_ferr));
    checkOutput({tag, "_ovr"},     16'(rx_bus.overrun),   16'(exp_ovr));
    checkOutput({tag, "_busy"},    16'(rx_bus.rx_busy),   16'h0);
  endtask

  task automatic modelReset();
    exp_buf = 8'h00; exp_9 = 1'b0; exp_pnd = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0;
  endtask

  task automatic modelClear();
    exp_pnd = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0;
  endtask

  task automatic modelComplete(input logic [7:0] d, input logic ninth, input logic stop, input logic clr_same);
    if (clr_same)     exp_ovr = 1'b0;
    else if (exp_pnd) exp_ovr = 1'b1;
    exp_buf  = d;
    exp_9    = prty_en ? ninth : 1'b0;
    exp_pnd  = 1'b1;
    exp_ferr = ~stop;
  endtask

  task automatic waitEdge();
    do @(posedge uart_clk); while (baud_edge !== 1'b1);
  endtask

  // One bit lasts uart_baud+1 sub-ticks; an optional one-cycle inverted glitch at position glitch_at.
  task automatic sendBit(input logic v, input int glitch_at, input logic set_clr);
    for (int i = 0; i <= int'(uart_baud); i++) begin
      @(negedge uart_clk);
      uart_rx = (i == glitch_at) ? ~v : v;
      if (set_clr && i == 0) rx_bus.rxpnd_clr = 1'b1;
      waitEdge();
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic ninth, input logic stop,
                               input int glitch_bit, input logic clr_in_stop);
    logic fb[11];
    int   n;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[i+1] = d[i];
    n = 9;
    if (prty_en) begin
      fb[9] = ninth;
      n = 10;
    end
    fb[n] = stop;
    n++;
    for (int k = 0; k < n; k++)
      sendBit(fb[k], (k == glitch_bit) ? int'(uart_baud[15:1]) + 1 : -1, clr_in_stop && (k == n - 1));
  endtask

  task automatic waitIdle(input string tag);
    int c = 0;
    while (rx_bus.rx_busy === 1'b1 && c < 5000) begin
      @(negedge uart_clk);
      c++;
    end
    checkOutput({tag, "_idle"}, 16'(rx_bus.rx_busy), 16'h0);
  endtask

  task automatic finishFrame(input string tag);
    @(negedge uart_clk);
    uart_rx = 1'b1;
    waitIdle(tag);
    repeat (2) @(negedge uart_clk);
    checkAll(tag);
  endtask

  task automatic clearPulse();
    @(negedge uart_clk);
    rx_bus.rxpnd_clr = 1'b1;
    @(negedge uart_clk);
    rx_bus.rxpnd_clr = 1'b0;
    modelClear();
  endtask

  task automatic sendChecked(input string tag, input logic [7:0] d, input logic ninth, input logic stop);
    applyStimulus(d, ninth, stop, -1, 1'b0);
    modelComplete(d, ninth, stop, 1'b0);
    finishFrame(tag);
  endtask

  initial begin
    logic [7:0] ab;
    logic [7:0] rd;
    logic       rn, rs;

    sys_rstn = 1'b0; uart_en = 1'b1; prty_en = 1'b0; uart_rx = 1'b1;
    uart_baud = 16'd7; rx_bus.rxpnd_clr = 1'b0;
    modelReset();
    repeat (3) @(negedge uart_clk);
    checkAll("reset");
    sys_rstn = 1'b1;
    repeat (4) @(negedge uart_clk);

    // Basic byte, then clear.
    sendChecked("t1", 8'hA5, 1'b0, 1'b1);
    clearPulse();
    @(negedge uart_clk);
    checkAll("t1_clr");

    // 9th bit both values.
    prty_en = 1'b1;
    sendChecked("t2_n1", 8'h3C, 1'b1, 1'b1);
    sendChecked("t2_n0", 8'h3C, 1'b0, 1'b1);
    prty_en = 1'b0;
    clearPulse();

    // False start: line low for only two sub-ticks.
    @(negedge uart_clk);
    uart_rx = 1'b0;
    waitEdge(); waitEdge();
    @(negedge uart_clk);
    uart_rx = 1'b1;
    @(negedge uart_clk);
    @(negedge uart_clk);
    checkOutput("fs_busy", 16'(rx_bus.rx_busy), 16'h1);
    repeat (12) @(negedge uart_clk);
    checkOutput("fs_idle", 16'(rx_bus.rx_busy), 16'h0);
    checkOutput("fs_pnd",  16'(rx_bus.rxpnd),   16'h0);

    // Majority vote rejects a one-cycle glitch in data bit 4.
    applyStimulus(8'hFF, 1'b0, 1'b1, 5, 1'b0);
    modelComplete(8'hFF, 1'b0, 1'b1, 1'b0);
    finishFrame("t3_glitch");
    clearPulse();

    // Frame error, then overrun, then clear.
    sendChecked("t4_ferr", 8'h12, 1'b0, 1'b0);
    sendChecked("t4_ovr",  8'h34, 1'b0, 1'b1);
    clearPulse();
    @(negedge uart_clk);
    checkAll("t4_clr");

    // Clear on the completing cycle: completion wins and overrun drops.
    sendChecked("t5_a", 8'h5A, 1'b0, 1'b1);
    sendChecked("t5_b", 8'hA6, 1'b0, 1'b1);
    applyStimulus(8'h81, 1'b0, 1'b1, -1, 1'b1);
    @(negedge uart_clk);
    uart_rx = 1'b1;
    for (int c = 0; c < 5000 && rx_bus.rx_busy === 1'b1; c++) @(negedge uart_clk);
    rx_bus.rxpnd_clr = 1'b0;
    modelComplete(8'h81, 1'b0, 1'b1, 1'b1);
    repeat (2) @(negedge uart_clk);
    checkAll("t5_same");

    // Shortest bit length takes the single-sample path.
    uart_baud = 16'd1;
    prty_en = 1'b1;
    sendChecked("b1", 8'hC3, 1'b1, 1'b1);
    uart_baud = 16'd7;
    prty_en = 1'b0;
    clearPulse();

    // Disable mid-frame, re-enable with line low, then a clean frame.
    ab = 8'h55;
    sendBit(1'b0, -1, 1'b0);
    for (int i = 0; i < 3; i++) sendBit(ab[i], -1, 1'b0);
    @(negedge uart_clk);
    uart_rx = ab[3];
    waitEdge(); waitEdge(); waitEdge();
    @(negedge uart_clk);
    checkOutput("ab_busy_pre", 16'(rx_bus.rx_busy), 16'h1);
    uart_en = 1'b0;
    uart_rx = 1'b0;
    @(negedge uart_clk);
    checkAll("ab_off");
    uart_en = 1'b1;
    repeat (30) @(negedge uart_clk);
    checkAll("ab_reen");
    uart_rx = 1'b1;
    repeat (4) @(negedge uart_clk);
    sendChecked("ab_66", 8'h66, 1'b0, 1'b1);

    // Reset mid-frame.
    sendBit(1'b0, -1, 1'b0);
    sendBit(1'b1, -1, 1'b0);
    sendBit(1'b0, -1, 1'b0);
    @(negedge uart_clk);
    sys_rstn = 1'b0;
    modelReset();
    @(negedge uart_clk);
    checkAll("rst_mid");
    uart_rx = 1'b1;
    sys_rstn = 1'b1;
    repeat (4) @(negedge uart_clk);

    // Randomized frames with random sub-tick density, bit length, parity and clears.
    for (int f = 0; f < 16; f++) begin
      edge_mode = int'($urandom_range(0, 1));
      uart_baud = 16'($urandom_range(8, 20));
      prty_en   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) clearPulse();
      rd = 8'($urandom);
      rn = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 4) != 0);
      repeat (3) @(negedge uart_clk);
      sendChecked($sformatf("rnd%0d", f), rd, rn, rs);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
